// File: rtl/sparrow_pkg.sv
// Shared types for the sparrow instruction encoder:
// opcodes, instruction formats and immediate limits.
package sparrow_pkg;

  typedef enum logic [6:0] {
    OP_LOAD   = 7'h03,
    OP_IMM    = 7'h13,
    OP_AUIPC  = 7'h17,
    OP_STORE  = 7'h23,
    OP_OP     = 7'h33,
    OP_LUI    = 7'h37,
    OP_BRANCH = 7'h63,
    OP_JALR   = 7'h67,
    OP_JAL    = 7'h6F
  } riscv_op_e;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_NONE
  } riscv_fmt_e;

  localparam logic signed [31:0] IMM12_MIN = -32'sd2048;
  localparam logic signed [31:0] IMM12_MAX = 32'sd2047;
  localparam logic signed [31:0] IMMB_MIN  = -32'sd4096;
  localparam logic signed [31:0] IMMB_MAX  = 32'sd4094;
  localparam logic signed [31:0] IMMJ_MIN  = -32'sd1048576;
  localparam logic signed [31:0] IMMJ_MAX  = 32'sd1048574;

endpackage

// File: rtl/sparrow_encode_pack.sv
// Combinational packer: opcode to format, field packing
// and immediate legality check.
module sparrow_encode_pack
  import sparrow_pkg::*;
(
  input  logic [6:0]  op_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [31:0] imm_i,
  output riscv_fmt_e  fmt_o,
  output logic [31:0] word_o,
  output logic        illegal_o
);

  logic signed [31:0] simm;
  assign simm = $signed(imm_i);

  always_comb begin
    fmt_o = FMT_NONE;
    unique case (1'b1)
      op_i == OP_OP:     fmt_o = FMT_R;
      op_i == OP_IMM,
      op_i == OP_LOAD,
      op_i == OP_JALR:   fmt_o = FMT_I;
      op_i == OP_STORE:  fmt_o = FMT_S;
      op_i == OP_BRANCH: fmt_o = FMT_B;
      op_i == OP_LUI,
      op_i == OP_AUIPC:  fmt_o = FMT_U;
      op_i == OP_JAL:    fmt_o = FMT_J;
      default:           fmt_o = FMT_NONE;
    endcase
  end

  always_comb begin
    word_o    = '0;
    illegal_o = 1'b0;
    unique case (fmt_o)
      FMT_R: begin
        word_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, op_i};
      end
      FMT_I: begin
        word_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, op_i};
        illegal_o = (simm < IMM12_MIN) || (simm > IMM12_MAX);
      end
      FMT_S: begin
        word_o = {imm_i[11:5], rs2_i, rs1_i, funct3_i,
                  imm_i[4:0], op_i};
        illegal_o = (simm < IMM12_MIN) || (simm > IMM12_MAX);
      end
      FMT_B: begin
        word_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i,
                  funct3_i, imm_i[4:1], imm_i[11], op_i};
        illegal_o = (simm < IMMB_MIN) || (simm > IMMB_MAX)
                  || imm_i[0];
      end
      FMT_U: begin
        word_o = {imm_i[31:12], rd_i, op_i};
        illegal_o = imm_i[11:0] != 12'd0;
      end
      FMT_J: begin
        word_o = {imm_i[20], imm_i[10:1], imm_i[11],
                  imm_i[19:12], rd_i, op_i};
        illegal_o = (simm < IMMJ_MIN) || (simm > IMMJ_MAX)
                  || imm_i[0];
      end
      default: begin
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/sparrow_encode.sv
// Streaming RV32I encoder: one output register with
// address stamping and a saturating reject counter.
module sparrow_encode
  import sparrow_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [6:0]  op_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [31:0] imm_i,
  input  logic        addr_load_i,
  input  logic [31:0] addr_i,
  output logic        imem_valid_o,
  input  logic        imem_ready_i,
  output logic [31:0] imem_addr_o,
  output logic [31:0] imem_wdata_o,
  output logic        err_o,
  output logic [7:0]  err_count_o
);

  typedef enum logic {EMPTY, FULL} state_e;

  state_e      state_q, state_d;
  riscv_fmt_e  fmt;
  logic [31:0] word;
  logic        illegal;
  logic        accept, good, bad, load_out;
  logic [31:0] addr_q;

  sparrow_encode_pack u_pack (
    .op_i      (op_i),
    .rd_i      (rd_i),
    .rs1_i     (rs1_i),
    .rs2_i     (rs2_i),
    .funct3_i  (funct3_i),
    .funct7_i  (funct7_i),
    .imm_i     (imm_i),
    .fmt_o     (fmt),
    .word_o    (word),
    .illegal_o (illegal)
  );

  assign imem_valid_o = (state_q == FULL);
  assign req_ready_o  = !imem_valid_o || imem_ready_i;
  assign accept = req_valid_i && req_ready_o;
  assign bad    = illegal || (fmt == FMT_NONE);
  assign good   = accept && !bad;

  always_comb begin
    state_d  = state_q;
    load_out = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (good) begin
          state_d  = FULL;
          load_out = 1'b1;
        end
      end
      FULL: begin
        if (imem_ready_i) begin
          load_out = good;
          state_d  = good ? FULL : EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= EMPTY;
      imem_addr_o  <= '0;
      imem_wdata_o <= '0;
      addr_q       <= BASE_ADDR;
      err_o        <= 1'b0;
      err_count_o  <= '0;
    end else begin
      state_q <= state_d;
      err_o   <= accept && bad;
      if (load_out) begin
        imem_addr_o  <= addr_q;
        imem_wdata_o <= word;
      end
      // a load overrides the increment of a coinciding accept
      if (addr_load_i) begin
        addr_q <= addr_i;
      end else if (good) begin
        addr_q <= addr_q + 32'd4;
      end
      if (accept && bad && err_count_o != 8'hFF) begin
        err_count_o <= err_count_o + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_sparrow_encode.sv
// Directed bench for sparrow_encode with
// hand-computed instruction words.
module tb_sparrow_encode;

  logic        clk, rst;
  logic        req_valid, req_ready;
  logic [6:0]  op;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm;
  logic        addr_load;
  logic [31:0] addr_in;
  logic        imem_valid, imem_ready;
  logic [31:0] imem_addr, imem_wdata;
  logic        err;
  logic [7:0]  err_count;

  int n_chk  = 0;
  int n_pass = 0;

  sparrow_encode #(.BASE_ADDR(32'h0)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .op_i         (op),
    .rd_i         (rd),
    .rs1_i        (rs1),
    .rs2_i        (rs2),
    .funct3_i     (f3),
    .funct7_i     (f7),
    .imm_i        (imm),
    .addr_load_i  (addr_load),
    .addr_i       (addr_in),
    .imem_valid_o (imem_valid),
    .imem_ready_i (imem_ready),
    .imem_addr_o  (imem_addr),
    .imem_wdata_o (imem_wdata),
    .err_o        (err),
    .err_count_o  (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fields(input logic [6:0] o,
                        input logic [4:0] d, s1, s2,
                        input logic [2:0] fn3,
                        input logic [6:0] fn7,
                        input logic [31:0] im);
    op = o; rd = d; rs1 = s1; rs2 = s2;
    f3 = fn3; f7 = fn7; imm = im;
  endtask

  task automatic send(input logic [6:0] o,
                      input logic [4:0] d, s1, s2,
                      input logic [2:0] fn3,
                      input logic [6:0] fn7,
                      input logic [31:0] im);
    fields(o, d, s1, s2, fn3, fn7, im);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; imem_ready = 1'b1;
    addr_load = 1'b0; addr_in = '0;
    fields(7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    #2;
    check("rst_valid", {31'd0, imem_valid}, 32'd0);
    check("rst_addr", imem_addr, 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_cnt", {24'd0, err_count}, 32'd0);
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    tick();
    rst = 1'b0;

    send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    check("addi_valid", {31'd0, imem_valid}, 32'd1);
    check("addi_word", imem_wdata, 32'h00500093);
    check("addi_addr", imem_addr, 32'h0);
    tick();
    check("drain_valid", {31'd0, imem_valid}, 32'd0);

    do_reset();
    send(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    check("add_word", imem_wdata, 32'h002081B3);
    check("add_addr", imem_addr, 32'h0);
    send(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, -32'sd4);
    check("beq_valid", {31'd0, imem_valid}, 32'd1);
    check("beq_word", imem_wdata, 32'hFE208EE3);
    check("beq_addr", imem_addr, 32'h4);

    send(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    check("jal_word", imem_wdata, 32'h001000EF);
    check("jal_addr", imem_addr, 32'h8);
    send(7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
    check("sw_word", imem_wdata, 32'h0020A423);
    send(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);
    check("lui_word", imem_wdata, 32'h123452B7);
    send(7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd2048);
    check("imin_word", imem_wdata, 32'h80000013);
    check("imin_addr", imem_addr, 32'h14);
    check("imin_err", {31'd0, err}, 32'd0);
    tick();

    send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    check("rej1_err", {31'd0, err}, 32'd1);
    check("rej1_valid", {31'd0, imem_valid}, 32'd0);
    check("rej1_cnt", {24'd0, err_count}, 32'd1);
    send(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3);
    check("rej2_err", {31'd0, err}, 32'd1);
    check("rej2_cnt", {24'd0, err_count}, 32'd2);
    send(7'h7F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    check("rej3_err", {31'd0, err}, 32'd1);
    check("rej3_valid", {31'd0, imem_valid}, 32'd0);
    check("rej3_cnt", {24'd0, err_count}, 32'd3);
    send(7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000123);
    check("rej_u_cnt", {24'd0, err_count}, 32'd4);
    tick();
    check("err_pulse", {31'd0, err}, 32'd0);

    send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    check("post_rej_addr", imem_addr, 32'h18);

    for (int i = 0; i < 260; i++)
      send(7'h7F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    check("sat_cnt", {24'd0, err_count}, 32'd255);

    imem_ready = 1'b0;
    send(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    fields(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_valid", {31'd0, imem_valid}, 32'd1);
      check("bp_word", imem_wdata, 32'h001000EF);
      check("bp_addr", imem_addr, 32'h1C);
      check("bp_ready", {31'd0, req_ready}, 32'd0);
    end
    imem_ready = 1'b1;
    #1;
    check("bp_rel_ready", {31'd0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0;
    check("bp_next_word", imem_wdata, 32'h002081B3);
    check("bp_next_addr", imem_addr, 32'h20);

    fields(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    req_valid = 1'b1;
    addr_load = 1'b1;
    addr_in = 32'hFFFF_FFFC;
    tick();
    req_valid = 1'b0;
    addr_load = 1'b0;
    check("ld_old_addr", imem_addr, 32'h24);
    send(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    check("ld_new_addr", imem_addr, 32'hFFFF_FFFC);
    send(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, -32'sd4);
    check("wrap_addr", imem_addr, 32'h0);

    imem_ready = 1'b0;
    send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    check("pend_valid", {31'd0, imem_valid}, 32'd1);
    rst = 1'b1;
    #1;
    check("async_drop", {31'd0, imem_valid}, 32'd0);
    check("rst_ready_mid", {31'd0, req_ready}, 32'd1);
    tick();
    rst = 1'b0;
    imem_ready = 1'b1;
    tick();
    check("post_rst_idle", {31'd0, imem_valid}, 32'd0);
    send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    check("post_rst_addr", imem_addr, 32'h0);
    check("post_rst_cnt", {24'd0, err_count}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
